// File: rtl/led_serial_driver.sv
// led_serial_driver
// Shifts a WIDTH-bit LED word MSB-first into an external 595-style
// serial-in/parallel-out chain. A frame goes out once after reset, whenever
// the word differs from the last one sent, and on a resend request.
// The resend port is named force_req because "force" is a reserved word.

module led_serial_driver #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] led_in,
    input  logic             force_req,
    output logic             ser_data,
    output logic             ser_clk,
    output logic             ser_latch,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] last_sent;
    logic             pending;
    logic [CNT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_cnt;

    logic             div_last;
    logic             last_bit;
    logic             trigger;
    logic [WIDTH-1:0] shift_next;

    // Phase timing, frame completion and start conditions.
    assign div_last   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_bit   = (bit_cnt == CNT_W'(WIDTH - 1));
    assign trigger    = pending || force_req || (led_in != last_sent);
    assign shift_next = shift_reg << 1;

    // Frame sequencer: all outputs are registered here, so nothing on the
    // serial pins depends combinationally on led_in or force_req.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // pending resets high so the chain is refreshed after every reset.
            state      <= IDLE;
            shift_reg  <= '0;
            last_sent  <= '0;
            pending    <= 1'b1;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            ser_data   <= 1'b0;
            ser_clk    <= 1'b0;
            ser_latch  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere in this block, so
            // every branch sees the pre-edge register values; the default
            // below is overridden only in the LATCH exit branch.
            frame_done <= 1'b0;

            // Resend requests during a frame collapse into one follow-up frame.
            if (state != IDLE && force_req) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (trigger) begin
                        shift_reg <= led_in;
                        last_sent <= led_in;
                        pending   <= 1'b0;
                        bit_cnt   <= '0;
                        div_cnt   <= '0;
                        busy      <= 1'b1;
                        ser_clk   <= 1'b0;
                        ser_data  <= led_in[WIDTH-1];
                        state     <= SHIFT_LO;
                    end
                end

                SHIFT_LO: begin
                    // shift_reg is pre-shifted, so its MSB is the bit on the pin.
                    ser_data <= shift_reg[WIDTH-1];
                    if (div_last) begin
                        div_cnt <= '0;
                        ser_clk <= 1'b1;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                SHIFT_HI: begin
                    if (div_last) begin
                        div_cnt   <= '0;
                        ser_clk   <= 1'b0;
                        shift_reg <= shift_next;
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                        if (last_bit) begin
                            ser_data  <= 1'b0;
                            ser_latch <= 1'b1;
                            state     <= LATCH;
                        end else begin
                            ser_data <= shift_next[WIDTH-1];
                            state    <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                LATCH: begin
                    if (div_last) begin
                        div_cnt    <= '0;
                        ser_latch  <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_serial_driver.sv
// tb_led_serial_driver
// Two instances: CLK_DIV=4 (main scenarios) and CLK_DIV=1 (ramp sequence).
// A 595-style chain model per instance captures the latched word; expected
// words are queued when stimulus is applied and popped on frame_done.

module tb_led_serial_driver;

    localparam int W    = 16;
    localparam int D0   = 4;
    localparam int D1   = 1;
    localparam int LEN0 = 2 * W * D0 + D0;
    localparam int LEN1 = 2 * W * D1 + D1;

    logic         clk = 1'b0;
    logic         rst_v [2];
    logic [W-1:0] led   [2];
    logic         frc   [2];
    logic         sd    [2];
    logic         sc    [2];
    logic         lat   [2];
    logic         bsy   [2];
    logic         fd    [2];

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];

    logic [W-1:0] chain     [2];
    logic [W-1:0] latched   [2];
    int           edge_cnt  [2];
    int           latch_cnt [2];
    int           latch_len [2];
    int           busy_len  [2];
    int           frame_cnt [2];
    int           gap       [2];
    int           last_gap  [2];
    logic         prev_sc   [2];
    logic         prev_sd   [2];
    logic         prev_lat  [2];
    logic         prev_bsy  [2];

    always #5 clk = ~clk;

    led_serial_driver #(.WIDTH(W), .CLK_DIV(D0)) dut0 (
        .clk       (clk),
        .rst       (rst_v[0]),
        .led_in    (led[0]),
        .force_req (frc[0]),
        .ser_data  (sd[0]),
        .ser_clk   (sc[0]),
        .ser_latch (lat[0]),
        .busy      (bsy[0]),
        .frame_done(fd[0])
    );

    led_serial_driver #(.WIDTH(W), .CLK_DIV(D1)) dut1 (
        .clk       (clk),
        .rst       (rst_v[1]),
        .led_in    (led[1]),
        .force_req (frc[1]),
        .ser_data  (sd[1]),
        .ser_clk   (sc[1]),
        .ser_latch (lat[1]),
        .busy      (bsy[1]),
        .frame_done(fd[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // External chain model and per-frame protocol checks, sampled on negedge.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (!rst_v[c]) begin
                edge_cnt[c]  = 0;
                latch_cnt[c] = 0;
                latch_len[c] = 0;
                busy_len[c]  = 0;
                gap[c]       = 1000;
                prev_sc[c]   = 1'b0;
                prev_sd[c]   = 1'b0;
                prev_lat[c]  = 1'b0;
                prev_bsy[c]  = 1'b0;
            end else begin
                if (sc[c] && !prev_sc[c]) begin
                    check("data_setup", sd[c], prev_sd[c]);
                    chain[c] = {chain[c][W-2:0], sd[c]};
                    edge_cnt[c]++;
                end else if (sc[c] && prev_sc[c]) begin
                    check("data_hold", sd[c], prev_sd[c]);
                end
                if (lat[c] && !prev_lat[c]) begin
                    latched[c] = chain[c];
                    latch_cnt[c]++;
                end
                if (lat[c]) latch_len[c]++;
                if (bsy[c]) busy_len[c]++;
                if (bsy[c] && !prev_bsy[c]) last_gap[c] = gap[c];

                if (fd[c]) begin
                    check("done_busy_low", bsy[c], 1'b0);
                    check("busy_length", busy_len[c], (c == 0) ? LEN0 : LEN1);
                    check("clk_edges", edge_cnt[c], W);
                    check("latch_pulses", latch_cnt[c], 1);
                    check("latch_width", latch_len[c], (c == 0) ? D0 : D1);
                    if (c == 0) begin
                        if (q0.size() == 0) check("unexpected_frame0", 1, 0);
                        else check("frame_word0", latched[0], q0.pop_front());
                    end else begin
                        if (q1.size() == 0) check("unexpected_frame1", 1, 0);
                        else check("frame_word1", latched[1], q1.pop_front());
                    end
                    frame_cnt[c]++;
                    edge_cnt[c]  = 0;
                    latch_cnt[c] = 0;
                    latch_len[c] = 0;
                    busy_len[c]  = 0;
                    gap[c]       = 1;
                end else if (!bsy[c]) begin
                    gap[c]++;
                end
                prev_sc[c]  = sc[c];
                prev_sd[c]  = sd[c];
                prev_lat[c] = lat[c];
                prev_bsy[c] = bsy[c];
            end
        end
    end

    task automatic wait_frames(input int c, input int n, input int budget);
        int k = 0;
        while (frame_cnt[c] < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_frames_timeout", (frame_cnt[c] >= n), 1);
    endtask

    task automatic wait_edges(input int c, input int n, input int budget);
        int k = 0;
        while (edge_cnt[c] < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_edges_timeout", (edge_cnt[c] >= n), 1);
    endtask

    task automatic pulse_force0();
        frc[0] = 1'b1;
        @(negedge clk);
        frc[0] = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            rst_v[c] = 1'b0; led[c] = '0; frc[c] = 1'b0;
            chain[c] = '0; latched[c] = '0; frame_cnt[c] = 0; last_gap[c] = 0;
        end

        // Reset state, then the single power-on frame of 0x0000.
        repeat (3) @(negedge clk);
        check("reset_outputs0", {sd[0], sc[0], lat[0], bsy[0], fd[0]}, 0);
        check("reset_outputs1", {sd[1], sc[1], lat[1], bsy[1], fd[1]}, 0);
        q0.push_back(16'h0000);
        q1.push_back(16'h0000);
        rst_v[0] = 1'b1;
        rst_v[1] = 1'b1;
        @(negedge clk);
        check("trigger_after_release", bsy[0], 1'b1);
        wait_frames(0, 1, LEN0 + 20);
        repeat (500) @(negedge clk);
        check("quiet_frames", frame_cnt[0], 1);
        check("quiet_busy", bsy[0], 1'b0);

        // Plain word change.
        led[0] = 16'hA5C3;
        q0.push_back(16'hA5C3);
        @(negedge clk);
        check("change_latency", bsy[0], 1'b1);
        wait_frames(0, 2, LEN0 + 20);
        check("latched_a5c3", latched[0], 16'hA5C3);

        // Word changes mid-frame: first frame unchanged, second back-to-back.
        led[0] = 16'h0001;
        q0.push_back(16'h0001);
        wait_edges(0, 5, LEN0);
        led[0] = 16'h8000;
        q0.push_back(16'h8000);
        wait_frames(0, 4, 2 * LEN0 + 40);
        check("back_to_back_gap", last_gap[0], 1);
        repeat (300) @(negedge clk);
        check("no_third_frame", frame_cnt[0], 4);

        // Resend requests: one in idle, three during that frame -> two frames.
        led[0] = 16'h00FF;
        q0.push_back(16'h00FF);
        wait_frames(0, 5, LEN0 + 20);
        repeat (10) @(negedge clk);
        q0.push_back(16'h00FF);
        pulse_force0();
        wait_edges(0, 2, LEN0);
        pulse_force0();
        wait_edges(0, 8, LEN0);
        pulse_force0();
        wait_edges(0, 12, LEN0);
        pulse_force0();
        q0.push_back(16'h00FF);
        wait_frames(0, 7, 2 * LEN0 + 40);
        check("pending_gap", last_gap[0], 1);
        repeat (300) @(negedge clk);
        check("force_frames", frame_cnt[0], 7);

        // Reset during bit 7 of a 0xFFFF frame.
        led[0] = 16'hFFFF;
        wait_edges(0, 7, LEN0);
        @(posedge clk);
        #2;
        rst_v[0] = 1'b0;
        #1;
        check("async_reset_outputs", {sd[0], sc[0], lat[0], bsy[0], fd[0]}, 0);
        repeat (5) @(negedge clk);
        check("chain_kept", latched[0], 16'h00FF);
        check("no_frame_on_abort", frame_cnt[0], 7);
        q0.push_back(16'hFFFF);
        rst_v[0] = 1'b1;
        wait_frames(0, 8, LEN0 + 20);
        check("latched_ffff", latched[0], 16'hFFFF);

        // CLK_DIV=1 ramp on the second instance.
        check("div1_reset_frame", frame_cnt[1], 1);
        led[1] = 16'h0001; q1.push_back(16'h0001);
        repeat (40) @(negedge clk);
        led[1] = 16'h0003; q1.push_back(16'h0003);
        repeat (40) @(negedge clk);
        led[1] = 16'h0007; q1.push_back(16'h0007);
        wait_frames(1, 4, LEN1 + 20);
        repeat (50) @(negedge clk);
        check("div1_frames", frame_cnt[1], 4);
        check("div1_latched", latched[1], 16'h0007);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
